muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multi-cycle RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Receives forwarded operands and an M-extension op code, and holds busy so the hazard logic stalls the pipeline.
- Returns a 32-bit result with a one-cycle done pulse for the execute/memory pipeline register to capture.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- MD_ITER, 32, iteration cycles for normal mul/div ops; must equal XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  launch request; sampled only in IDLE
- mdCode  input  3  md_codes_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- rs1F  input  XLEN  forwarded rs1 value (multiplicand/dividend)
- rs2F  input  XLEN  forwarded rs2 value (multiplier/divisor)
- flush  input  1  abort any in-flight op (branch mispredict/trap)
- busy  output  1  high from the cycle after accepted start until done or abort
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  final result; held until the next accepted start

Behaviour:
- Reset is synchronous and active-low: rst_n=0 at a rising edge forces state IDLE, busy=0, done=0, result=0, and clears all internal registers. Reset mid-operation discards the op with no done.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE: start=1 at edge N latches operands and mdCode, computes magnitudes and sign flags, and sets counter=0.
  - Special divide cases go to FIN directly.
  - Otherwise go to MUL or DIV.
- start while busy=1 is ignored; the upstream stall guarantees it is not re-presented.
- MUL: radix-2 shift-add on 32-bit magnitudes into a 64-bit product, one bit per cycle, MD_ITER cycles.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
  - The product is negated if the operand signs differ.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- DIV: restoring division on magnitudes, one quotient bit per cycle, MD_ITER cycles.
  - The quotient is negated if signed and the signs differ.
  - The remainder takes the dividend's sign (DIV/REM only).
- FIN: register the result, done=1 for exactly one cycle, then return to IDLE. busy drops in the same cycle done rises.
- Latency:
  - Normal ops: done=1 in cycle N+MD_ITER+1 (N+33).
  - Special cases: done=1 in cycle N+1.
- Divide-by-zero (rs2F=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1F.
- Signed overflow (DIV/REM with rs1F=0x80000000, rs2F=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Zero multiplier or multiplicand takes the normal path; there is no early-out.
- flush=1 in any state other than IDLE forces IDLE at the next edge, with busy=0 and no done; result keeps its previous value.
  - flush together with start in IDLE: the start is dropped.
  - Reset has priority over flush; flush has priority over FSM progress.
- done is never asserted without a preceding accepted start. result changes only in the FIN cycle.

Decomposition:
- Add md_codes_t (3-bit enum, encoded as funct3 order MUL=0 through REMU=7) and MD_ITER to core_types_pkg.
- Add helpers isSignedRs1(md_codes_t) and isSignedRs2(md_codes_t) to coreUtils.
- Natural sub-module: md_operand_prep, combinational.
  - Takes rs1F, rs2F and mdCode.
  - Produces magnitudes, sign flags, the divide-by-zero flag and the overflow flag.
- The FSM, datapath and result fix-up stay in muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at N -> busy high N+1..N+32, done at N+33, result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE; MULH 0x80000000*0x80000000 -> result=0x40000000; MULHSU 0xFFFFFFFF*0x00000002 -> result=0xFFFFFFFF.
- DIV -7/2 -> result=0xFFFFFFFD; REM -7/2 -> result=0xFFFFFFFF; DIVU 100/7 -> result=14; REMU 100/7 -> result=2; each done at N+33.
- DIVU 5/0 -> done at N+1, result=0xFFFFFFFF; REM 5/0 -> result=5; DIV 0x80000000/0xFFFFFFFF -> result=0x80000000 at N+1; REM on the same operands -> result=0.
- Start DIV, flush at N+10 -> busy=0 at N+11, no done ever, result unchanged; a new MUL 3*4 at N+12 -> result=12 at N+45.
- Start MUL, rst_n=0 at N+5 -> busy=0, done=0, result=0 after that edge; start pulses while busy=1 produce no extra done.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
// Op codes follow funct3 order so decode can pass funct3 straight through.
package muldiv_unit_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_codes_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN
    } md_state_t;

    function automatic logic isSignedRs1(md_codes_t c);
        return c inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic isSignedRs2(md_codes_t c);
        return c inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

    function automatic logic isDivOp(md_codes_t c);
        return c inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic isRemOp(md_codes_t c);
        return c inside {MD_REM, MD_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit_md_operand_prep.sv
// Combinational operand conditioning: magnitudes, sign flags and the
// divide special-case flags consumed by the iterative mul/div FSM.
module md_operand_prep
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1F,
    input  logic [XLEN-1:0] rs2F,
    input  md_codes_t       mdCode,
    output logic [XLEN-1:0] mag1,
    output logic [XLEN-1:0] mag2,
    output logic            neg1,
    output logic            neg2,
    output logic            div_zero,
    output logic            div_ovf
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        neg1 = isSignedRs1(mdCode) & rs1F[XLEN-1];
        neg2 = isSignedRs2(mdCode) & rs2F[XLEN-1];
        mag1 = neg1 ? (~rs1F + 1'b1) : rs1F;
        mag2 = neg2 ? (~rs2F + 1'b1) : rs2F;
        div_zero = (rs2F == '0);
        // Only signed divides can overflow: most-negative / -1.
        div_ovf = (mdCode inside {MD_DIV, MD_REM})
                  && (rs1F == MOST_NEG)
                  && (rs2F == '1);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with a one-cycle done pulse.
module muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int MD_ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      mdCode,
    input  logic [XLEN-1:0] rs1F,
    input  logic [XLEN-1:0] rs2F,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import muldiv_unit_pkg::*;

    localparam int CW = $clog2(MD_ITER);

    md_codes_t code_in;
    md_codes_t code_q;
    md_state_t state;
    md_state_t state_nxt;

    logic [XLEN-1:0]   p_mag1;
    logic [XLEN-1:0]   p_mag2;
    logic              p_neg1;
    logic              p_neg2;
    logic              p_dz;
    logic              p_ovf;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_res;
    logic              neg_rem;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;

    logic              accept;
    logic              special;
    logic              last;
    logic [XLEN-1:0]   spec_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res;

    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quo_step;
    logic [XLEN-1:0]   div_res;

    assign code_in = md_codes_t'(mdCode);

    md_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .rs1F     (rs1F),
        .rs2F     (rs2F),
        .mdCode   (code_in),
        .mag1     (p_mag1),
        .mag2     (p_mag2),
        .neg1     (p_neg1),
        .neg2     (p_neg2),
        .div_zero (p_dz),
        .div_ovf  (p_ovf)
    );

    assign accept  = (state == S_IDLE) && start && !flush;
    assign special = isDivOp(code_in) && (p_dz || p_ovf);
    assign last    = (cnt == CW'(MD_ITER - 1));

    // Div-by-zero and overflow answers come straight from the operands.
    always_comb begin
        spec_res = '0;
        if (p_dz) begin
            spec_res = isRemOp(code_in) ? rs1F : '1;
        end else begin
            spec_res = isRemOp(code_in) ? '0 : rs1F;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_nxt = S_FIN;
                    end else if (isDivOp(code_in)) begin
                        state_nxt = S_DIV;
                    end else begin
                        state_nxt = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
    end

    // Multiplier lives in prod's low half and shifts out as partials shift in.
    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]}
                  + (prod[0] ? {1'b0, mag_a} : '0);
        prod_step = {mul_sum, prod[XLEN-1:1]};
        prod_fix  = neg_res ? (~prod_step + 1'b1) : prod_step;
        mul_res   = (code_q == MD_MUL) ? prod_fix[XLEN-1:0]
                                       : prod_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        div_shift = {rem, quo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ge    = !div_diff[XLEN];
        rem_step  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        quo_step  = {quo[XLEN-2:0], div_ge};
        if (isRemOp(code_q)) begin
            div_res = neg_rem ? (~rem_step + 1'b1) : rem_step;
        end else begin
            div_res = neg_res ? (~quo_step + 1'b1) : quo_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q  <= MD_MUL;
            mag_a   <= '0;
            mag_b   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            cnt     <= '0;
            prod    <= '0;
            rem     <= '0;
            quo     <= '0;
            result  <= '0;
        end else if (accept) begin
            code_q  <= code_in;
            mag_a   <= p_mag1;
            mag_b   <= p_mag2;
            neg_res <= p_neg1 ^ p_neg2;
            neg_rem <= p_neg1;
            cnt     <= '0;
            prod    <= {{XLEN{1'b0}}, p_mag2};
            rem     <= '0;
            quo     <= p_mag1;
            if (special) begin
                result <= spec_res;
            end
        end else if (!flush) begin
            if (state == S_MUL) begin
                prod <= prod_step;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    result <= mul_res;
                end
            end else if (state == S_DIV) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt + CW'(1);
                if (last) begin
                    result <= div_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for the iterative mul/div unit.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mdCode;
    logic [31:0] rs1F;
    logic [31:0] rs2F;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_chk;
    int n_err;

    muldiv_unit #(
        .XLEN    (32),
        .MD_ITER (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mdCode (mdCode),
        .rs1F   (rs1F),
        .rs2F   (rs2F),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input md_codes_t code, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdCode = code;
        rs1F   = a;
        rs2F   = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Launch, then measure latency, busy cycles and final value.
    task automatic run(input string tag, input md_codes_t code,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
        int k;
        int bc;
        launch(code, a, b);
        k  = 1;
        bc = 0;
        while (!done && k < 60) begin
            if (busy) bc++;
            @(posedge clk);
            #1 k++;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_busycyc"}, bc, lat - 1);
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 0);
        chk(tag, result, exp);
        @(posedge clk);
        #1 chk({tag, "_pulse"}, {31'b0, done}, 0);
    endtask

    task automatic watch_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
    endtask

    initial begin
        int seen;
        n_chk  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        mdCode = 3'd0;
        rs1F   = '0;
        rs2F   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_result", result, 0);
        rst_n = 1'b1;

        run("mul_neg", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 33);
        run("mulh", MD_MULH, 32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 33);
        run("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        run("mul_zero", MD_MUL, 32'd0, 32'd9, 32'd0, 33);
        run("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run("remu", MD_REMU, 32'd100, 32'd7, 32'd2, 33);
        run("divu_z", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("rem_z", MD_REM, 32'd5, 32'd0, 32'd5, 1);
        run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 1);
        run("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33);

        // Flush mid-divide: no done, result keeps 0x55555555.
        launch(MD_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 0);
        chk("flush_done", {31'b0, done}, 0);
        watch_done(30, seen);
        chk("flush_nodone", seen, 0);
        chk("flush_result", result, 32'h5555_5555);
        run("after_flush", MD_MUL, 32'd3, 32'd4, 32'd12, 33);

        // Flush together with start in IDLE drops the start.
        @(negedge clk);
        start  = 1'b1;
        flush  = 1'b1;
        mdCode = MD_DIVU;
        rs1F   = 32'd5;
        rs2F   = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {31'b0, busy}, 0);
        watch_done(5, seen);
        chk("flush_start_nodone", seen, 0);
        chk("flush_start_result", result, 32'd12);

        // Reset mid-multiply.
        launch(MD_MUL, 32'd9, 32'd9);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mrst_busy", {31'b0, busy}, 0);
        chk("mrst_done", {31'b0, done}, 0);
        chk("mrst_result", result, 0);
        watch_done(40, seen);
        chk("mrst_nodone", seen, 0);

        // Start pulses while busy are ignored.
        launch(MD_MUL, 32'd5, 32'd6);
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i >= 3 && i <= 6) begin
                start  = 1'b1;
                mdCode = MD_DIVU;
                rs1F   = 32'd1;
                rs2F   = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1 if (done) seen++;
        end
        start = 1'b0;
        chk("busy_start_dones", seen, 1);
        chk("busy_start_result", result, 32'd30);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
